tap_ir_dr: RTL

TAP_IR_DR -- requirements
Module: tap_ir_dr

---
 rtl/tap_pkg.sv | 50 +++++
 rtl/tap_dr_shift.sv | 32 +++
 rtl/tap_ir_dr.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: controller state codes, opcodes, IR capture
// pattern and the instruction-to-data-register decode.
package tap_pkg;

    typedef enum logic [3:0] {
        ST_EX2DR = 4'h0,
        ST_EX1DR = 4'h1,
        ST_SHDR  = 4'h2,
        ST_PAUDR = 4'h3,
        ST_SELIR = 4'h4,
        ST_UPDDR = 4'h5,
        ST_CAPDR = 4'h6,
        ST_SELDR = 4'h7,
        ST_EX2IR = 4'h8,
        ST_EX1IR = 4'h9,
        ST_SHIR  = 4'hA,
        ST_PAUIR = 4'hB,
        ST_RTI   = 4'hC,
        ST_UPDIR = 4'hD,
        ST_CAPIR = 4'hE,
        ST_TLR   = 4'hF
    } tap_state_e;

    localparam logic [3:0] OP_IDCODE  = 4'h1;
    localparam logic [3:0] OP_BYPASS  = 4'hF;
    localparam logic [3:0] OP_USER    = 4'h8;
    localparam logic [3:0] IR_CAPTURE = 4'b0101;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

    // Unknown opcodes fall through to BYPASS.
    function automatic dr_sel_e dr_decode(input logic [3:0] op);
        dr_sel_e sel;
        sel = DR_BYPASS;
        if (op == OP_IDCODE) begin
            sel = DR_IDCODE;
        end
`ifdef TAP_USERREG_EN
        if (op == OP_USER) begin
            sel = DR_USER;
        end
`endif
        return sel;
    endfunction

endpackage

// File: rtl/tap_dr_shift.sv
// Generic TAP data register: parallel capture, right shift (sdi into MSB).
// Ports: clk_i, rst_ni (sync, active-low), cap_i, shift_i, load_i[W],
//        sdi_i, q_o[W] (register contents), so_o (current LSB). W >= 2.
module tap_dr_shift #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cap_i,
    input  logic         shift_i,
    input  logic [W-1:0] load_i,
    input  logic         sdi_i,
    output logic [W-1:0] q_o,
    output logic         so_o
);

    logic [W-1:0] sh_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else if (cap_i) begin
            sh_q <= load_i;
        end else if (shift_i) begin
            sh_q <= {sdi_i, sh_q[W-1:1]};
        end
    end

    assign q_o  = sh_q;
    assign so_o = sh_q[0];

endmodule

// File: rtl/tap_ir_dr.sv
// TAP instruction register plus IDCODE / BYPASS / USER data registers,
// driven by the observed TAP controller state.
// Ports: GCLK_Pad clock, TRST_Pad sync active-low reset, state_obs[3:0],
//        TDI_Pad, user_in[USER_W] in; TDO_Pad, TDO_en, ir_q[3:0],
//        user_out[USER_W], user_upd out.
// Macro TAP_USERREG_EN adds the USER instruction and its register;
// without it opcode 8 is BYPASS and user_out/user_upd stay 0.
module tap_ir_dr
    import tap_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
    parameter int          USER_W     = 8
) (
    input  logic              GCLK_Pad,
    input  logic              TRST_Pad,
    input  logic [3:0]        state_obs,
    input  logic              TDI_Pad,
    input  logic [USER_W-1:0] user_in,
    output logic              TDO_Pad,
    output logic              TDO_en,
    output logic [3:0]        ir_q,
    output logic [USER_W-1:0] user_out,
    output logic              user_upd
);

    tap_state_e st;
    dr_sel_e    sel;

    logic [3:0] ir_shift_q;
    logic       tdo_q;
    logic       tdo_en_q;
    logic       bypass_q;
    logic       id_so;
    logic       user_so;
    logic       dr_so;
    logic [31:0] unused_id_q;

    assign st  = tap_state_e'(state_obs);
    assign sel = dr_decode(ir_q);

    tap_dr_shift #(
        .W(32)
    ) u_idcode (
        .clk_i   (GCLK_Pad),
        .rst_ni  (TRST_Pad),
        .cap_i   (st == ST_CAPDR && sel == DR_IDCODE),
        .shift_i (st == ST_SHDR && sel == DR_IDCODE),
        .load_i  (IDCODE_VAL),
        .sdi_i   (TDI_Pad),
        .q_o     (unused_id_q),
        .so_o    (id_so)
    );

`ifdef TAP_USERREG_EN
    logic [USER_W-1:0] user_sh;
    logic [USER_W-1:0] user_out_q;
    logic              user_upd_q;

    tap_dr_shift #(
        .W(USER_W)
    ) u_user (
        .clk_i   (GCLK_Pad),
        .rst_ni  (TRST_Pad),
        .cap_i   (st == ST_CAPDR && sel == DR_USER),
        .shift_i (st == ST_SHDR && sel == DR_USER),
        .load_i  (user_in),
        .sdi_i   (TDI_Pad),
        .q_o     (user_sh),
        .so_o    (user_so)
    );

    // user_out survives TLR; only TRST clears it.
    always_ff @(posedge GCLK_Pad) begin
        if (!TRST_Pad) begin
            user_out_q <= '0;
            user_upd_q <= 1'b0;
        end else begin
            user_upd_q <= 1'b0;
            if (st == ST_UPDDR && sel == DR_USER) begin
                user_out_q <= user_sh;
                user_upd_q <= 1'b1;
            end
        end
    end

    assign user_out = user_out_q;
    assign user_upd = user_upd_q;
`else
    logic unused_user;

    assign unused_user = ^user_in;
    assign user_so     = 1'b0;
    assign user_out    = '0;
    assign user_upd    = 1'b0;
`endif

    always_comb begin
        dr_so = bypass_q;
        unique case (sel)
            DR_IDCODE: dr_so = id_so;
            DR_USER:   dr_so = user_so;
            default:   dr_so = bypass_q;
        endcase
    end

    always_ff @(posedge GCLK_Pad) begin
        if (!TRST_Pad) begin
            ir_q       <= OP_IDCODE;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            tdo_q      <= 1'b0;
            tdo_en_q   <= 1'b0;
        end else begin
            tdo_en_q <= (st == ST_SHIR) || (st == ST_SHDR);
            case (st)
                ST_TLR: begin
                    ir_q       <= OP_IDCODE;
                    ir_shift_q <= '0;
                end
                ST_CAPIR: ir_shift_q <= IR_CAPTURE;
                ST_SHIR: begin
                    ir_shift_q <= {TDI_Pad, ir_shift_q[3:1]};
                    tdo_q      <= ir_shift_q[0];
                end
                ST_UPDIR: ir_q <= ir_shift_q;
                ST_CAPDR: begin
                    if (sel == DR_BYPASS) begin
                        bypass_q <= 1'b0;
                    end
                end
                ST_SHDR: begin
                    tdo_q <= dr_so;
                    if (sel == DR_BYPASS) begin
                        bypass_q <= TDI_Pad;
                    end
                end
                default: ;
            endcase
        end
    end

    assign TDO_Pad = tdo_q;
    assign TDO_en  = tdo_en_q;

endmodule
